// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch
// Issue-side reader for the register file. It tracks pending writes in a busy
// scoreboard, stalls on RAW/WAW hazards and forwards same-cycle writebacks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_src1,
  input  logic [ADDR_W-1:0]        in_src2,
  input  logic                     in_use1,
  input  logic                     in_use2,
  input  logic [ADDR_W-1:0]        in_dst,
  input  logic                     in_wr,
  output logic [ADDR_W-1:0]        rf_rd1,
  output logic [ADDR_W-1:0]        rf_rd2,
  input  logic [DATA_W-1:0]        rf_rd1_data,
  input  logic [DATA_W-1:0]        rf_rd2_data,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_dst,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_op1,
  output logic [DATA_W-1:0]        out_op2,
  output logic [ADDR_W-1:0]        out_dst,
  output logic                     out_wr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     wb_spurious
);

  localparam int NREG = 2**ADDR_W;

  logic              clr1;
  logic              clr2;
  logic              clrd;
  logic              raw1;
  logic              raw2;
  logic              waw;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   busy_next;

  assign rf_rd1 = in_src1;
  assign rf_rd2 = in_src2;

  // A writeback landing this cycle resolves the hazard on its register.
  always_comb begin
    clr1     = wb_valid && (wb_dst == in_src1);
    clr2     = wb_valid && (wb_dst == in_src2);
    clrd     = wb_valid && (wb_dst == in_dst);
    raw1     = in_use1 && busy[in_src1] && !clr1;
    raw2     = in_use2 && busy[in_src2] && !clr2;
    waw      = in_wr && busy[in_dst] && !clrd;
    stall    = raw1 || raw2 || waw;
    in_ready = !stall && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // The register file commits on the same edge, so its read data is stale here.
  always_comb begin
    op1_sel = clr1 ? wb_data : rf_rd1_data;
    op2_sel = clr2 ? wb_data : rf_rd2_data;
  end

  // Set wins over a simultaneous clear: the new write is still outstanding.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && in_wr) begin
      set_vec[in_dst] = 1'b1;
    end
    if (wb_valid) begin
      clr_vec[wb_dst] = 1'b1;
    end
    busy_next = set_vec | (busy & ~clr_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      wb_spurious <= 1'b0;
      out_valid   <= 1'b0;
      out_wr      <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_dst     <= '0;
    end else begin
      busy <= busy_next;
      if (wb_valid && !busy[wb_dst]) begin
        wb_spurious <= 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_op1   <= op1_sel;
        out_op2   <= op2_sel;
        out_dst   <= in_dst;
        out_wr    <= in_wr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios plus randomized traffic
// checked against a pending-write-count model of the scoreboard.
`default_nettype none

module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_src1, in_src2, in_dst;
  logic          in_use1, in_use2, in_wr;
  logic [AW-1:0] rf_rd1, rf_rd2;
  logic [DW-1:0] rf_rd1_data, rf_rd2_data;
  logic          wb_valid;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready, out_wr;
  logic [DW-1:0] out_op1, out_op2;
  logic [AW-1:0] out_dst;
  logic [7:0]    busy;
  logic          wb_spurious;

  logic [DW-1:0] rf [8];
  assign rf_rd1_data = rf[rf_rd1];
  assign rf_rd2_data = rf[rf_rd2];

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
    .in_dst(in_dst), .in_wr(in_wr),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst), .out_wr(out_wr),
    .busy(busy), .wb_spurious(wb_spurious)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count of outstanding writes per register
  int            pend [8];
  bit            m_spur;
  bit            m_valid;
  logic [DW-1:0] m_op1, m_op2;
  logic [AW-1:0] m_dst;
  bit            m_wr;
  bit            exp_ready;
  logic          obs_ready;

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (pend[r] > 0);
    return b;
  endfunction

  // An instruction may go when no register it touches still has a write
  // outstanding once this cycle's writeback has landed.
  function automatic bit model_ready();
    int after [8];
    bit st;
    for (int r = 0; r < 8; r++) after[r] = pend[r];
    if (wb_valid && after[wb_dst] > 0) after[wb_dst]--;
    st = (in_use1 && after[in_src1] > 0) || (in_use2 && after[in_src2] > 0) ||
         (in_wr && after[in_dst] > 0);
    return !st && (!m_valid || out_ready);
  endfunction

  // One clock: inputs already driven at the falling edge; returns at the next one.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] nv [8];
    #1;
    exp_ready = model_ready();
    obs_ready = in_ready;
    acc = in_valid && exp_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) nv[r] = rf[r];
    if (wb_valid) nv[wb_dst] = wb_data;
    if (rst) begin
      for (int r = 0; r < 8; r++) pend[r] = 0;
      m_spur = 0; m_valid = 0; m_wr = 0; m_op1 = '0; m_op2 = '0; m_dst = '0;
    end else begin
      if (wb_valid) begin
        if (pend[wb_dst] == 0) m_spur = 1;
        else pend[wb_dst]--;
      end
      if (acc) begin
        m_valid = 1; m_op1 = nv[in_src1]; m_op2 = nv[in_src2];
        m_dst = in_dst; m_wr = in_wr;
        if (in_wr) pend[in_dst]++;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
    for (int r = 0; r < 8; r++) rf[r] = nv[r];
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] s1, input logic u1, input logic [AW-1:0] s2,
                       input logic u2, input logic [AW-1:0] d, input logic w);
    in_valid = 1; in_src1 = s1; in_use1 = u1; in_src2 = s2; in_use2 = u2;
    in_dst = d; in_wr = w;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; wb_valid = 0; out_ready = 1;
    tick(); tick();
    rst = 0;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (out_valid !== 1'b0 || out_wr !== 1'b0 || wb_spurious !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b w=%b s=%b exp 0 0 0", out_valid, out_wr, wb_spurious); end
    checks++; if (out_op1 !== '0 || out_op2 !== '0 || out_dst !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %0d exp 0", out_op1, out_op2, out_dst); end
  endtask

  task automatic test_basic();
    rf[1] = 32'h11; rf[2] = 32'h22;
    issue(3'd1, 1, 3'd2, 1, 3'd3, 1);
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", obs_ready); end
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h11 || out_op2 !== 32'h22 || out_dst !== 3'd3 || out_wr !== 1'b1) begin
      errors++; $display("FAIL basic_out got v=%b %h %h d=%0d w=%b exp 1 11 22 3 1", out_valid, out_op1, out_op2, out_dst, out_wr); end
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL basic_busy got %h exp 08", busy); end
  endtask

  task automatic test_raw_forward();
    issue(3'd3, 1, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cyc %0d got %b exp 0", i, obs_ready); end
    end
    wb_valid = 1; wb_dst = 3'd3; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 0; in_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", obs_ready); end
    checks++; if (out_op1 !== 32'hDEADBEEF || out_valid !== 1'b1) begin
      errors++; $display("FAIL raw_forward got %h v=%b exp deadbeef 1", out_op1, out_valid); end
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL raw_busy3 got %b exp 0", busy[3]); end
  endtask

  task automatic test_waw();
    issue(3'd0, 0, 3'd0, 0, 3'd5, 1);
    tick();
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL waw_setup got %h exp 20", busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL waw_stall cyc %0d got %b exp 0", i, obs_ready); end
    end
    wb_valid = 1; wb_dst = 3'd5; wb_data = 32'h5555_0001;
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL waw_accept got %b exp 1", obs_ready); end
    checks++; if (busy[5] !== 1'b1 || out_dst !== 3'd5) begin
      errors++; $display("FAIL waw_setwins got busy5=%b dst=%0d exp 1 5", busy[5], out_dst); end
    wb_data = 32'h5555_0002;
    tick();
    wb_valid = 0;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL waw_drain got %h exp 00", busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a1, a2;
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    a1 = rf[1]; a2 = rf[2];
    issue(3'd1, 1, 3'd2, 1, 3'd7, 0);
    tick();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_first got %b exp 1", obs_ready); end
    issue(3'd6, 1, 3'd4, 1, 3'd2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, obs_ready); end
      checks++; if (out_valid !== 1'b1 || out_op1 !== a1 || out_op2 !== a2 || out_dst !== 3'd7) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b %h %h %0d exp 1 %h %h 7", i, out_valid, out_op1, out_op2, out_dst, a1, a2); end
    end
    out_ready = 1;
    tick();
    checks++; if (obs_ready !== 1'b1 || out_op1 !== rf[6] || out_dst !== 3'd2) begin
      errors++; $display("FAIL b2b_first got r=%b %h %0d exp 1 %h 2", obs_ready, out_op1, out_dst, rf[6]); end
    issue(3'd5, 1, 3'd3, 1, 3'd1, 0);
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_op1 !== rf[5] || out_op2 !== rf[3] || out_dst !== 3'd1) begin
      errors++; $display("FAIL b2b_second got r=%b v=%b %h %h %0d exp 1 1 %h %h 1", obs_ready, out_valid, out_op1, out_op2, out_dst, rf[5], rf[3]); end
  endtask

  task automatic test_unused_spurious();
    issue(3'd0, 0, 3'd0, 0, 3'd4, 1);
    tick();
    issue(3'd0, 1, 3'd4, 0, 3'd0, 0);
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1 || busy[4] !== 1'b1) begin
      errors++; $display("FAIL unused_src got r=%b busy4=%b exp 1 1", obs_ready, busy[4]); end
    checks++; if (wb_spurious !== 1'b0) begin errors++; $display("FAIL spur_pre got %b exp 0", wb_spurious); end
    wb_valid = 1; wb_dst = 3'd6; wb_data = 32'h6666_6666;
    tick();
    wb_valid = 0;
    checks++; if (wb_spurious !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", wb_spurious); end
    tick(); tick();
    checks++; if (wb_spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", wb_spurious); end
  endtask

  task automatic test_reset_mid();
    rst = 1; tick(); rst = 0;
    issue(3'd0, 1, 3'd0, 1, 3'd1, 1);
    wb_valid = 1; wb_dst = 3'd6; wb_data = 32'h1;
    tick();
    wb_valid = 0;
    issue(3'd1, 0, 3'd0, 0, 3'd3, 1); tick();
    issue(3'd2, 1, 3'd7, 1, 3'd5, 1); tick();
    in_valid = 0; out_ready = 0;
    checks++; if (busy !== 8'h2A || out_valid !== 1'b1 || wb_spurious !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got busy=%h v=%b s=%b exp 2a 1 1", busy, out_valid, wb_spurious); end
    rst = 1; tick(); rst = 0; out_ready = 1;
    checks++; if (busy !== 8'h00 || out_valid !== 1'b0 || wb_spurious !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got busy=%h v=%b s=%b exp 00 0 0", busy, out_valid, wb_spurious); end
    checks++; if (out_op1 !== '0 || out_op2 !== '0 || out_dst !== '0 || out_wr !== 1'b0) begin
      errors++; $display("FAIL rstmid_data got %h %h %0d %b exp 0", out_op1, out_op2, out_dst, out_wr); end
  endtask

  task automatic test_random();
    int cand [$];
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom); in_src1 = 3'($urandom); in_src2 = 3'($urandom);
      in_use1 = 1'($urandom); in_use2 = 1'($urandom); in_dst = 3'($urandom);
      in_wr = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int r = 0; r < 8; r++) if (pend[r] > 0) cand.push_back(r);
      wb_valid = 0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1; wb_dst = 3'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        wb_valid = 1; wb_dst = 3'($urandom);
      end
      wb_data = $urandom;
      #1;
      checks++; if (rf_rd1 !== in_src1 || rf_rd2 !== in_src2) begin
        errors++; $display("FAIL rnd_rdaddr cyc %0d got %0d %0d exp %0d %0d", c, rf_rd1, rf_rd2, in_src1, in_src2); end
      tick();
      checks++; if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, obs_ready, exp_ready); end
      checks++; if (out_valid !== m_valid || (m_valid && (out_op1 !== m_op1 || out_op2 !== m_op2 ||
                    out_dst !== m_dst || out_wr !== m_wr))) begin
        errors++; $display("FAIL rnd_out cyc %0d got v=%b %h %h %0d %b exp v=%b %h %h %0d %b", c,
          out_valid, out_op1, out_op2, out_dst, out_wr, m_valid, m_op1, m_op2, m_dst, m_wr); end
      checks++; if (busy !== m_busy() || wb_spurious !== m_spur) begin
        errors++; $display("FAIL rnd_sb cyc %0d got %h %b exp %h %b", c, busy, wb_spurious, m_busy(), m_spur); end
    end
    in_valid = 0; wb_valid = 0; out_ready = 1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_src1 = '0; in_src2 = '0; in_use1 = 0; in_use2 = 0;
    in_dst = '0; in_wr = 0; wb_valid = 0; wb_dst = '0; wb_data = '0; out_ready = 1;
    for (int r = 0; r < 8; r++) begin rf[r] = $urandom; pend[r] = 0; end
    m_spur = 0; m_valid = 0; m_wr = 0; m_op1 = '0; m_op2 = '0; m_dst = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_raw_forward();
    test_waw();
    test_back_to_back();
    test_unused_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue-side reader for the 8-entry, 32-bit register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Tracks pending writebacks in a per-register busy scoreboard, stalls on RAW and WAW hazards, and forwards same-cycle writeback data.
- Presents registered operands to the execute stage.

Parameters:
- DATA_W, 32, operand and writeback data width
- ADDR_W, 3, register address width; NREG = 2**ADDR_W entries

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  decoded instruction present
- in_ready  output  1  instruction accepted this cycle when in_valid && in_ready
- in_src1  input  ADDR_W  source 1 register
- in_src2  input  ADDR_W  source 2 register
- in_use1  input  1  source 1 is read
- in_use2  input  1  source 2 is read
- in_dst  input  ADDR_W  destination register
- in_wr  input  1  instruction will write in_dst
- rf_rd1  output  ADDR_W  register file read address 1; equals in_src1, combinational
- rf_rd2  output  ADDR_W  register file read address 2; equals in_src2, combinational
- rf_rd1_data  input  DATA_W  register file read data 1, combinational from rf_rd1
- rf_rd2_data  input  DATA_W  register file read data 2
- wb_valid  input  1  writeback this cycle; same signal as the register file write enable
- wb_dst  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback data
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute accepts operands
- out_op1  output  DATA_W  operand 1
- out_op2  output  DATA_W  operand 2
- out_dst  output  ADDR_W  destination
- out_wr  output  1  destination write flag
- busy  output  NREG  scoreboard, bit i set means a write to register i is pending
- wb_spurious  output  1  sticky flag: a writeback arrived for a non-busy register

Behaviour:
- Reset (rst high at a clk edge) clears:
  - busy to 0
  - out_valid, out_wr and wb_spurious to 0
  - out_op1, out_op2 and out_dst to 0
- Reset mid-operation discards the held output and all pending-write tracking; downstream stages are reset together.
- Clear terms, evaluated combinationally in the same cycle:
  - clr1 = wb_valid && wb_dst==in_src1
  - clr2 = wb_valid && wb_dst==in_src2
  - clrd = wb_valid && wb_dst==in_dst
- Hazard terms:
  - raw1 = in_use1 && busy[in_src1] && !clr1
  - raw2 = in_use2 && busy[in_src2] && !clr2
  - waw = in_wr && busy[in_dst] && !clrd
- stall = raw1 || raw2 || waw.
- in_ready = !stall && (!out_valid || out_ready). This is combinational in the in_* fields, busy, wb_* and out_ready.
- Operand select:
  - op1 = clr1 ? wb_data : rf_rd1_data; op2 = clr2 ? wb_data : rf_rd2_data.
  - Forwarding is needed because the register file commits on the same clk edge, so its read data is stale in the writeback cycle.
- Accept (in_valid && in_ready) at an edge:
  - out_op1, out_op2, out_dst and out_wr load from the selected values and the in_* fields.
  - out_valid becomes 1.
  - Latency is 1 cycle from accept to out_valid.
- Output hold:
  - out_valid && !out_ready: all out_* hold stable.
  - No accept and out_ready high: out_valid clears at the edge.
- Back-to-back: an accept in the same cycle as out_ready reloads the output; full throughput is one instruction per cycle.
- Scoreboard, per register i at each edge:
  - set_i = accept && in_wr && in_dst==i
  - clr_i = wb_valid && wb_dst==i
  - busy[i] next = set_i || (busy[i] && !clr_i); set wins over a simultaneous clear.
- Single-bit tracking is sufficient because the WAW stall permits at most one pending write per register.
- Unused sources never stall: use=0 ignores busy even when the source register is busy.
- wb_spurious sets when wb_valid && !busy[wb_dst] at an edge. Only rst clears it. The register file still takes the write; this block only flags it.
- No register is hardwired to zero; all NREG entries are tracked identically.

Test Plan:
- Basic issue:
  - Stimulus: reset, rf returns r1=0x11, r2=0x22; issue src1=1, src2=2, use both, dst=3, wr=1, out_ready=1.
  - Required: next cycle out_valid=1, out_op1=0x11, out_op2=0x22, out_dst=3, busy=0x08.
- RAW stall and forward:
  - Stimulus: with busy[3]=1, present src1=3, use1=1.
  - Required: in_ready=0 until the cycle where wb_valid=1, wb_dst=3, wb_data=0xDEADBEEF. In that cycle in_ready=1; next out_op1=0xDEADBEEF and busy[3]=0.
- WAW and simultaneous set/clear:
  - Stimulus: busy[5]=1; issue dst=5, wr=1.
  - Required: stalls. On the cycle wb_dst=5 arrives, accept occurs and busy[5] remains 1.
- Backpressure:
  - Stimulus: out_ready=0 after one accept.
  - Required: out_* hold stable and in_ready=0. Raising out_ready re-enables accept, with back-to-back accepts on consecutive cycles.
- Unused source and spurious writeback:
  - Stimulus: busy[4]=1, src2=4, use2=0.
  - Required: accepts with no stall.
  - Stimulus: wb_valid with wb_dst=6 and busy[6]=0.
  - Required: wb_spurious=1 from the next cycle and it stays set.
- Reset mid-operation:
  - Stimulus: busy=0x2A, out_valid=1, assert rst for one cycle.
  - Required: busy=0, out_valid=0, wb_spurious=0, and out_op1/out_op2/out_dst=0 after the edge.
